// File: rtl/layer_pkg.sv
// Shared definitions for the fully-connected layer sequencer.
//   state_t      : sequencer FSM states
//   REG_*        : CPU slave register map of layer_seq
//   DOT_REG_*    : register map of the downstream dot-product unit
//   Q16_ONE      : 1.0 in Q16.16
package layer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG_W,
    CFG_A,
    CFG_N,
    START,
    BIAS_REQ,
    BIAS_WAIT,
    RESULT,
    WRITE_OUT
  } state_t;

  localparam logic [3:0] REG_START = 4'd0;
  localparam logic [3:0] REG_BIAS  = 4'd1;
  localparam logic [3:0] REG_W     = 4'd2;
  localparam logic [3:0] REG_A     = 4'd3;
  localparam logic [3:0] REG_OUT   = 4'd4;
  localparam logic [3:0] REG_N     = 4'd5;
  localparam logic [3:0] REG_M     = 4'd6;
  localparam logic [3:0] REG_RELU  = 4'd7;

  localparam logic [3:0] DOT_REG_START  = 4'd0;
  localparam logic [3:0] DOT_REG_RESULT = 4'd1;
  localparam logic [3:0] DOT_REG_W      = 4'd2;
  localparam logic [3:0] DOT_REG_A      = 4'd3;
  localparam logic [3:0] DOT_REG_N      = 4'd5;

  localparam logic [31:0] Q16_ONE = 32'h0001_0000;

endpackage

// File: rtl/bias_relu.sv
// Bias add and optional ReLU for one output neuron (combinational).
//   result_i  : dot-product result, Q16.16
//   bias_i    : neuron bias, Q16.16
//   relu_en_i : clamp negative sums to zero when set
//   y_o       : activation, Q16.16 (sum wraps modulo 2^32)
module bias_relu (
  input  logic [31:0] result_i,
  input  logic [31:0] bias_i,
  input  logic        relu_en_i,
  output logic [31:0] y_o
);

  logic [31:0] sum;

  always_comb begin
    sum = result_i + bias_i;
    y_o = (relu_en_i && sum[31]) ? '0 : sum;
  end

endmodule

// File: rtl/layer_seq.sv
// Fully-connected layer sequencer: for each output neuron j it programs and
// starts the dot unit, fetches b[j] from SDRAM, adds bias, applies optional
// ReLU and writes the activation to SRAM.
//   slave_*  : CPU slave; reg 0 write = start, read = done count;
//              regs 1-7 = bias_base, w_base, a_base, out_base, N, M, relu_en
//   dot_*    : master to the dot-product unit slave port
//   mem_*    : SDRAM read master (bias fetch)
//   sram_*   : SRAM write master (activations)
// All master outputs are decoded from state and registers only.
module layer_seq
  import layer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        dot_waitrequest,
  output logic [3:0]  dot_address,
  output logic        dot_read,
  input  logic [31:0] dot_readdata,
  output logic        dot_write,
  output logic [31:0] dot_writedata,
  input  logic        mem_waitrequest,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  input  logic        sram_waitrequest,
  output logic [31:0] sram_address,
  output logic        sram_write,
  output logic [31:0] sram_writedata
);

  state_t      state_q, state_d;
  logic [31:0] bias_base_q, bias_base_d;
  logic [31:0] w_base_q, w_base_d;
  logic [31:0] a_base_q, a_base_d;
  logic [31:0] out_base_q, out_base_d;
  logic [31:0] n_q, n_d;
  logic [31:0] m_q, m_d;
  logic        relu_q, relu_d;
  logic [31:0] j_q, j_d;
  logic [31:0] w_ptr_q, w_ptr_d;
  logic [31:0] done_q, done_d;
  logic [31:0] bias_q, bias_d;
  logic [31:0] result_q, result_d;
  logic [31:0] y;
  logic [31:0] j_off;

  bias_relu u_bias_relu (
    .result_i  (result_q),
    .bias_i    (bias_q),
    .relu_en_i (relu_q),
    .y_o       (y)
  );

  assign j_off = {j_q[29:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bias_base_q <= '0;
      w_base_q    <= '0;
      a_base_q    <= '0;
      out_base_q  <= '0;
      n_q         <= '0;
      m_q         <= '0;
      relu_q      <= 1'b0;
      j_q         <= '0;
      w_ptr_q     <= '0;
      done_q      <= '0;
      bias_q      <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      bias_base_q <= bias_base_d;
      w_base_q    <= w_base_d;
      a_base_q    <= a_base_d;
      out_base_q  <= out_base_d;
      n_q         <= n_d;
      m_q         <= m_d;
      relu_q      <= relu_d;
      j_q         <= j_d;
      w_ptr_q     <= w_ptr_d;
      done_q      <= done_d;
      bias_q      <= bias_d;
      result_q    <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bias_base_d = bias_base_q;
    w_base_d    = w_base_q;
    a_base_d    = a_base_q;
    out_base_d  = out_base_q;
    n_d         = n_q;
    m_d         = m_q;
    relu_d      = relu_q;
    j_d         = j_q;
    w_ptr_d     = w_ptr_q;
    done_d      = done_q;
    bias_d      = bias_q;
    result_d    = result_q;

    slave_waitrequest = 1'b1;
    slave_readdata    = '0;
    dot_address       = '0;
    dot_read          = 1'b0;
    dot_write         = 1'b0;
    dot_writedata     = '0;
    mem_address       = '0;
    mem_read          = 1'b0;
    sram_address      = '0;
    sram_write        = 1'b0;
    sram_writedata    = '0;

    case (state_q)
      IDLE: begin
        slave_waitrequest = 1'b0;
        if (slave_read) begin
          case (slave_address)
            REG_START: slave_readdata = done_q;
            REG_BIAS:  slave_readdata = bias_base_q;
            REG_W:     slave_readdata = w_base_q;
            REG_A:     slave_readdata = a_base_q;
            REG_OUT:   slave_readdata = out_base_q;
            REG_N:     slave_readdata = n_q;
            REG_M:     slave_readdata = m_q;
            REG_RELU:  slave_readdata = {31'd0, relu_q};
            default:   slave_readdata = '0;
          endcase
        end
        if (slave_write) begin
          case (slave_address)
            REG_START: begin
              done_d  = '0;
              j_d     = '0;
              w_ptr_d = w_base_q;
              // With N = 0 the dot unit is never touched, so the result
              // register must already hold zero for every neuron.
              result_d = '0;
              if (m_q != '0) begin
                state_d = (n_q == '0) ? BIAS_REQ : CFG_W;
              end
            end
            REG_BIAS: bias_base_d = slave_writedata;
            REG_W:    w_base_d    = slave_writedata;
            REG_A:    a_base_d    = slave_writedata;
            REG_OUT:  out_base_d  = slave_writedata;
            REG_N:    n_d         = slave_writedata;
            REG_M:    m_d         = slave_writedata;
            REG_RELU: relu_d      = slave_writedata[0];
            default: ;
          endcase
        end
      end

      CFG_W: begin
        dot_write     = 1'b1;
        dot_address   = DOT_REG_W;
        dot_writedata = w_ptr_q;
        if (!dot_waitrequest) state_d = CFG_A;
      end

      CFG_A: begin
        dot_write     = 1'b1;
        dot_address   = DOT_REG_A;
        dot_writedata = a_base_q;
        if (!dot_waitrequest) state_d = CFG_N;
      end

      CFG_N: begin
        dot_write     = 1'b1;
        dot_address   = DOT_REG_N;
        dot_writedata = n_q;
        if (!dot_waitrequest) state_d = START;
      end

      START: begin
        dot_write     = 1'b1;
        dot_address   = DOT_REG_START;
        dot_writedata = '0;
        if (!dot_waitrequest) state_d = BIAS_REQ;
      end

      // Bias fetch runs while the dot unit is busy; RESULT then soaks up
      // whatever dot latency remains through dot_waitrequest.
      BIAS_REQ: begin
        mem_read    = 1'b1;
        mem_address = bias_base_q + j_off;
        if (!mem_waitrequest) state_d = BIAS_WAIT;
      end

      BIAS_WAIT: begin
        if (mem_readdatavalid) begin
          bias_d  = mem_readdata;
          state_d = (n_q == '0) ? WRITE_OUT : RESULT;
        end
      end

      RESULT: begin
        dot_read    = 1'b1;
        dot_address = DOT_REG_RESULT;
        if (!dot_waitrequest) begin
          result_d = dot_readdata;
          state_d  = WRITE_OUT;
        end
      end

      WRITE_OUT: begin
        sram_write     = 1'b1;
        sram_address   = out_base_q + j_off;
        sram_writedata = y;
        if (!sram_waitrequest) begin
          done_d  = done_q + 32'd1;
          j_d     = j_q + 32'd1;
          w_ptr_d = w_ptr_q + {n_q[29:0], 2'b00};
          if (j_d < m_q) begin
            state_d = (n_q == '0) ? BIAS_REQ : CFG_W;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_seq.sv
module tb_layer_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        dot_waitrequest;
  logic [3:0]  dot_address;
  logic        dot_read;
  logic [31:0] dot_readdata;
  logic        dot_write;
  logic [31:0] dot_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        sram_waitrequest;
  logic [31:0] sram_address;
  logic        sram_write;
  logic [31:0] sram_writedata;

  always #5 clk = ~clk;

  layer_seq dut (
    .clk               (clk),
    .rst               (rst),
    .slave_waitrequest (slave_waitrequest),
    .slave_address     (slave_address),
    .slave_read        (slave_read),
    .slave_readdata    (slave_readdata),
    .slave_write       (slave_write),
    .slave_writedata   (slave_writedata),
    .dot_waitrequest   (dot_waitrequest),
    .dot_address       (dot_address),
    .dot_read          (dot_read),
    .dot_readdata      (dot_readdata),
    .dot_write         (dot_write),
    .dot_writedata     (dot_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .sram_waitrequest  (sram_waitrequest),
    .sram_address      (sram_address),
    .sram_write        (sram_write),
    .sram_writedata    (sram_writedata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Shared word memory holding weights, activations and biases.
  logic [31:0] tb_mem [0:1023];

  // ---------------- SDRAM model ----------------
  int          mem_stall_cfg = 0;
  int          mem_left;
  logic [1:0]  rv_delay;
  logic [31:0] rv_data;

  assign mem_waitrequest   = mem_read && (mem_left != 0);
  assign mem_readdatavalid = (rv_delay == 2'd1);
  assign mem_readdata      = rv_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_left <= 0;
      rv_delay <= '0;
      rv_data  <= '0;
    end else begin
      if (!mem_read) mem_left <= mem_stall_cfg;
      else if (mem_left != 0) mem_left <= mem_left - 1;
      if (mem_read && !mem_waitrequest) begin
        rv_delay <= 2'd2;
        rv_data  <= tb_mem[mem_address[11:2]];
        mem_left <= mem_stall_cfg;
      end else if (rv_delay != 2'd0) begin
        rv_delay <= rv_delay - 2'd1;
      end
    end
  end

  // ---------------- SRAM model ----------------
  int sram_stall_cfg = 0;
  int sram_left;

  assign sram_waitrequest = sram_write && (sram_left != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) sram_left <= 0;
    else if (!sram_write) sram_left <= sram_stall_cfg;
    else if (sram_left != 0) sram_left <= sram_left - 1;
    else sram_left <= sram_stall_cfg;
  end

  // ---------------- dot unit model ----------------
  int          dot_busy_cfg = 3;
  int          dot_busy;
  logic [31:0] dw, da, dn, dot_res;

  function automatic logic [31:0] dot_compute(input logic [31:0] w, input logic [31:0] a,
                                              input logic [31:0] n);
    logic signed [63:0] acc;
    logic signed [63:0] wx, ax;
    acc = '0;
    for (int unsigned k = 0; k < n; k++) begin
      wx = {{32{tb_mem[w[11:2] + k][31]}}, tb_mem[w[11:2] + k]};
      ax = {{32{tb_mem[a[11:2] + k][31]}}, tb_mem[a[11:2] + k]};
      acc = acc + ((wx * ax) >>> 16);
    end
    return acc[31:0];
  endfunction

  assign dot_waitrequest = dot_read && (dot_busy != 0);
  assign dot_readdata    = dot_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_busy <= 0;
      dw <= '0; da <= '0; dn <= '0; dot_res <= '0;
    end else begin
      if (dot_busy != 0) dot_busy <= dot_busy - 1;
      if (dot_write && !dot_waitrequest) begin
        case (dot_address)
          4'd2: dw <= dot_writedata;
          4'd3: da <= dot_writedata;
          4'd5: dn <= dot_writedata;
          4'd0: begin
            dot_busy <= dot_busy_cfg;
            dot_res  <= dot_compute(dw, da, dn);
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] expw_q[$];
  wr_t         e;
  logic [31:0] ew;
  int sram_hs = 0, dot_wr_hs = 0;
  int mem_stall_cyc = 0, sram_stall_cyc = 0, dot_stall_cyc = 0;

  logic        pm_stall = 1'b0, pd_stall = 1'b0, ps_stall = 1'b0;
  logic [31:0] pm_addr, pd_data, ps_addr, ps_data;
  logic [3:0]  pd_addr;
  logic [1:0]  pd_ctl;

  always @(negedge clk) begin
    if (rst) begin
      pm_stall <= 1'b0;
      pd_stall <= 1'b0;
      ps_stall <= 1'b0;
    end else begin
      if (sram_write && !sram_waitrequest) begin
        sram_hs++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sram_unexpected: got write 0x%08h to 0x%08h, required none",
                   sram_writedata, sram_address);
        end else begin
          e = exp_q.pop_front();
          check("sram_addr", sram_address, e.addr);
          check("sram_data", sram_writedata, e.data);
        end
      end
      if (dot_write && !dot_waitrequest) begin
        dot_wr_hs++;
        if (dot_address == 4'd2) begin
          if (expw_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dot_w_unexpected: got w_ptr 0x%08h, required none", dot_writedata);
          end else begin
            ew = expw_q.pop_front();
            check("dot_w_ptr", dot_writedata, ew);
          end
        end
      end
      if (mem_read && mem_waitrequest) mem_stall_cyc++;
      if (sram_write && sram_waitrequest) sram_stall_cyc++;
      if (dot_read && dot_waitrequest) dot_stall_cyc++;

      // Master outputs must not move while their transfer is stalled.
      if (pm_stall) begin
        check("mem_hold_rd", {31'd0, mem_read}, 32'd1);
        check("mem_hold_addr", mem_address, pm_addr);
      end
      if (pd_stall) begin
        check("dot_hold_ctl", {30'd0, dot_read, dot_write}, {30'd0, pd_ctl});
        check("dot_hold_addr", {28'd0, dot_address}, {28'd0, pd_addr});
        check("dot_hold_data", dot_writedata, pd_data);
      end
      if (ps_stall) begin
        check("sram_hold_wr", {31'd0, sram_write}, 32'd1);
        check("sram_hold_addr", sram_address, ps_addr);
        check("sram_hold_data", sram_writedata, ps_data);
      end
      pm_stall <= mem_read && mem_waitrequest;
      pm_addr  <= mem_address;
      pd_stall <= (dot_read || dot_write) && dot_waitrequest;
      pd_ctl   <= {dot_read, dot_write};
      pd_addr  <= dot_address;
      pd_data  <= dot_writedata;
      ps_stall <= sram_write && sram_waitrequest;
      ps_addr  <= sram_address;
      ps_data  <= sram_writedata;
    end
  end

  // ---------------- CPU tasks ----------------
  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(posedge clk);
    #1;
    slave_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    slave_address = a;
    slave_read    = 1'b1;
    @(negedge clk);
    d = slave_readdata;
    @(posedge clk);
    #1;
    slave_read = 1'b0;
  endtask

  task automatic config_layer(input logic [31:0] bb, input logic [31:0] wb, input logic [31:0] ab,
                              input logic [31:0] ob, input logic [31:0] n, input logic [31:0] m,
                              input logic [31:0] relu);
    cpu_write(4'd1, bb);
    cpu_write(4'd2, wb);
    cpu_write(4'd3, ab);
    cpu_write(4'd4, ob);
    cpu_write(4'd5, n);
    cpu_write(4'd6, m);
    cpu_write(4'd7, relu);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (slave_waitrequest && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (slave_waitrequest) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got busy after 2000 cycles, required idle", name);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t t;
    t.addr = a;
    t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic push_multi();
    expw_q.push_back(32'h200);
    expw_q.push_back(32'h210);
    expw_q.push_back(32'h220);
    push_wr(32'h8000, 32'h0001_0000);
    push_wr(32'h8004, 32'h0002_4000);
    push_wr(32'h8008, 32'hFFFF_8000);
  endtask

  task automatic setup_multi_mem();
    for (int unsigned i = 128; i < 140; i++) tb_mem[i] = '0;
    tb_mem[128] = 32'h0001_0000;       // row0 = [1,0,0,0]
    tb_mem[133] = 32'h0002_0000;       // row1 = [0,2,0,0]
    tb_mem[139] = 32'hFFFF_0000;       // row2 = [0,0,0,-1]
    for (int unsigned i = 192; i < 196; i++) tb_mem[i] = 32'h0001_0000;
    tb_mem[64] = 32'h0000_0000;
    tb_mem[65] = 32'h0000_4000;        // 0.25
    tb_mem[66] = 32'h0000_8000;        // 0.5
  endtask

  logic [31:0] rd;
  int          base, snap;
  logic        bad;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int unsigned i = 0; i < 1024; i++) tb_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {26'd0, slave_waitrequest, dot_read, dot_write, mem_read, sram_write, 1'b0}, '0);
    check("rst_bus", dot_writedata | mem_address | sram_address | sram_writedata | {28'd0, dot_address}, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cpu_read(4'd0, rd);
    check("rst_done_count", rd, 32'd0);
    cpu_read(4'd6, rd);
    check("rst_m", rd, 32'd0);

    // Single neuron: 1*3 + 2*0.5 + 0.5 = 4.5
    tb_mem[128] = 32'h0001_0000; tb_mem[129] = 32'h0002_0000;
    tb_mem[192] = 32'h0003_0000; tb_mem[193] = 32'h0000_8000;
    tb_mem[64]  = 32'h0000_8000;
    config_layer(32'h100, 32'h200, 32'h300, 32'h8000, 32'd2, 32'd1, 32'd0);
    expw_q.push_back(32'h200);
    push_wr(32'h8000, 32'h0004_8000);
    cpu_write(4'd0, 32'd0);
    check("start_latency", {31'd0, dot_write}, 32'd1);
    check("start_dot_addr", {28'd0, dot_address}, 32'd2);
    wait_idle("single");
    cpu_read(4'd0, rd);
    check("single_done", rd, 32'd1);
    check("single_sb_empty", exp_q.size(), 32'd0);
    cpu_read(4'd5, rd);
    check("rd_n", rd, 32'd2);
    cpu_read(4'd1, rd);
    check("rd_bias_base", rd, 32'h100);
    cpu_read(4'd4, rd);
    check("rd_out_base", rd, 32'h8000);
    cpu_read(4'd9, rd);
    check("rd_unmapped", rd, 32'd0);

    // ReLU clamp: dot = 4.0, bias = -8.0
    tb_mem[128] = 32'h0001_0000; tb_mem[192] = 32'h0004_0000;
    tb_mem[64]  = 32'hFFF8_0000;
    config_layer(32'h100, 32'h200, 32'h300, 32'h8000, 32'd1, 32'd1, 32'd1);
    expw_q.push_back(32'h200);
    push_wr(32'h8000, 32'h0000_0000);
    cpu_write(4'd0, 32'd0);
    wait_idle("relu_on");
    cpu_read(4'd7, rd);
    check("rd_relu", rd, 32'd1);
    cpu_write(4'd7, 32'd0);
    expw_q.push_back(32'h200);
    push_wr(32'h8000, 32'hFFFC_0000);
    cpu_write(4'd0, 32'd0);
    wait_idle("relu_off");
    check("relu_sb_empty", exp_q.size(), 32'd0);

    // Multi-neuron, no stalls
    setup_multi_mem();
    config_layer(32'h100, 32'h200, 32'h300, 32'h8000, 32'd4, 32'd3, 32'd0);
    push_multi();
    snap = dot_wr_hs;
    cpu_write(4'd0, 32'd0);
    wait_idle("multi");
    cpu_read(4'd0, rd);
    check("multi_done", rd, 32'd3);
    check("multi_dot_writes", dot_wr_hs - snap, 32'd12);
    check("multi_sb_empty", exp_q.size() + expw_q.size(), 32'd0);

    // Same layer with stalls on every master
    mem_stall_cfg  = 5;
    sram_stall_cfg = 3;
    dot_busy_cfg   = 30;
    mem_stall_cyc = 0; sram_stall_cyc = 0; dot_stall_cyc = 0;
    push_multi();
    cpu_write(4'd0, 32'd0);
    wait_idle("stall");
    cpu_read(4'd0, rd);
    check("stall_done", rd, 32'd3);
    check("stall_mem_cycles", mem_stall_cyc, 32'd15);
    check("stall_sram_cycles", sram_stall_cyc, 32'd9);
    check("stall_dot_seen", {31'd0, dot_stall_cyc >= 20}, 32'd1);
    check("stall_sb_empty", exp_q.size() + expw_q.size(), 32'd0);
    mem_stall_cfg = 0; sram_stall_cfg = 0; dot_busy_cfg = 3;

    // M = 0: start is a no-op apart from clearing done_count
    cpu_write(4'd6, 32'd0);
    cpu_write(4'd0, 32'd0);
    bad = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (slave_waitrequest || dot_read || dot_write || mem_read || sram_write) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    check("m0_quiet", {31'd0, bad}, 32'd0);
    cpu_read(4'd0, rd);
    check("m0_done", rd, 32'd0);

    // N = 0: output is just the bias
    tb_mem[64] = 32'h0001_4000;
    config_layer(32'h100, 32'h200, 32'h300, 32'h8000, 32'd0, 32'd1, 32'd0);
    push_wr(32'h8000, 32'h0001_4000);
    snap = dot_wr_hs;
    cpu_write(4'd0, 32'd0);
    wait_idle("n0");
    check("n0_no_dot", dot_wr_hs - snap, 32'd0);
    cpu_read(4'd0, rd);
    check("n0_done", rd, 32'd1);
    check("n0_sb_empty", exp_q.size(), 32'd0);

    // Reset during RESULT of neuron 1, then re-run from scratch
    setup_multi_mem();
    config_layer(32'h100, 32'h200, 32'h300, 32'h8000, 32'd4, 32'd3, 32'd0);
    push_multi();
    base = sram_hs;
    cpu_write(4'd0, 32'd0);
    snap = 0;
    while (!(dot_read && sram_hs == base + 1) && snap < 500) begin
      @(posedge clk);
      #1;
      snap++;
    end
    check("rst_reach_result", {31'd0, dot_read}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ctl", {26'd0, slave_waitrequest, dot_read, dot_write, mem_read, sram_write, 1'b0}, '0);
    check("midrst_bus", dot_writedata | mem_address | sram_address | sram_writedata | {28'd0, dot_address}, '0);
    exp_q.delete();
    expw_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cpu_read(4'd0, rd);
    check("midrst_done", rd, 32'd0);
    cpu_read(4'd2, rd);
    check("midrst_w_base", rd, 32'd0);
    config_layer(32'h100, 32'h200, 32'h300, 32'h8000, 32'd4, 32'd3, 32'd0);
    push_multi();
    cpu_write(4'd0, 32'd0);
    wait_idle("rerun");
    cpu_read(4'd0, rd);
    check("rerun_done", rd, 32'd3);
    check("rerun_sb_empty", exp_q.size() + expw_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
